// File: rtl/pht_ctrl_pkg.sv
// Shared definitions for the gshare predictor history/update controller.
package pht_ctrl_pkg;

  // Default table index width (table depth is 2**INDEX) and update-queue depth.
  localparam int PHT_INDEX_DEFAULT = 10;
  localparam int PHT_DEPTH_DEFAULT = 4;

  // RUN accepts lookups; RECOVER blocks them for one cycle after a history repair.
  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } pht_state_e;

endpackage : pht_ctrl_pkg

// File: rtl/pht_ctrl_if.sv
// Lookup, resolve and table-port signals of the predictor controller.
// The slave side is the controller; the master side is the pipeline plus the table.
interface pht_ctrl_if
  import pht_ctrl_pkg::*;
#(
  parameter int INDEX = PHT_INDEX_DEFAULT
);

  // Fetch-stage lookup
  logic             lookup_valid;
  logic [31:0]      lookup_pc;
  logic             lookup_ready;
  logic [INDEX-1:0] pred_sel;
  logic             pred;
  logic [INDEX-1:0] lookup_hist;

  // Branch resolution
  logic             resolve_valid;
  logic [INDEX-1:0] resolve_idx;
  logic [INDEX-1:0] resolve_hist;
  logic             resolve_taken;
  logic             resolve_mispredict;
  logic             resolve_ready;

  // Table write port
  logic [INDEX-1:0] update_sel;
  logic             update;
  logic             up_down;

  modport slave (
    input  lookup_valid, lookup_pc, pred,
    input  resolve_valid, resolve_idx, resolve_hist, resolve_taken, resolve_mispredict,
    output lookup_ready, pred_sel, lookup_hist,
    output resolve_ready,
    output update_sel, update, up_down
  );

  modport master (
    output lookup_valid, lookup_pc, pred,
    output resolve_valid, resolve_idx, resolve_hist, resolve_taken, resolve_mispredict,
    input  lookup_ready, pred_sel, lookup_hist,
    input  resolve_ready,
    input  update_sel, update, up_down
  );

endinterface : pht_ctrl_if

// File: rtl/pht_update_fifo.sv
// Small circular queue holding pending predictor-table updates.
// Push is ignored when full and pop is ignored when empty, so a push and pop
// in the same cycle never bypass through an empty queue and never squeeze
// an extra entry into a full one.
module pht_update_fifo
  import pht_ctrl_pkg::*;
#(
  parameter int DEPTH = PHT_DEPTH_DEFAULT,
  parameter int WIDTH = PHT_INDEX_DEFAULT + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_pushData,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_popData,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_doPush  = i_push && !o_full;
  assign w_doPop   = i_pop && !o_empty;
  assign o_popData = r_mem[r_rdPtr];

  // Storage needs no reset: only entries below the count are ever read.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_pushData;
    end
  end

  // Pointers wrap naturally at DEPTH; the count tracks occupancy 0..DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : pht_update_fifo

// File: rtl/pht_ctrl.sv
// Gshare history and update controller: forms the table read index from the
// fetch PC and the speculative global history, repairs the history on a
// mispredict, and queues resolved outcomes for the table write port.
module pht_ctrl
  import pht_ctrl_pkg::*;
#(
  parameter int INDEX = PHT_INDEX_DEFAULT,
  parameter int DEPTH = PHT_DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  pht_ctrl_if.slave  bus
);

  pht_state_e       r_state;
  pht_state_e       w_stateNext;
  logic [INDEX-1:0] r_ghr;
  logic [INDEX-1:0] w_ghrNext;
  logic             w_lookupReady;
  logic             w_lookupAccept;
  logic             w_resolveAccept;
  logic             w_mispredict;
  logic             w_fifoFull;
  logic             w_fifoEmpty;
  logic             w_pop;
  logic [INDEX:0]   w_headEntry;
  logic             w_unusedBits;

  // Only the word-aligned index bits of the PC and the low history bits of the
  // checkpoint take part in the logic.
  assign w_unusedBits = ^{bus.lookup_pc[31:INDEX+2], bus.lookup_pc[1:0],
                          bus.resolve_hist[INDEX-1]};

  assign w_lookupAccept  = bus.lookup_valid && w_lookupReady;
  assign w_resolveAccept = bus.resolve_valid && !w_fifoFull;
  assign w_mispredict    = w_resolveAccept && bus.resolve_mispredict;
  assign w_pop           = !w_fifoEmpty && !stall;

  assign bus.pred_sel      = bus.lookup_pc[INDEX+1:2] ^ r_ghr;
  assign bus.lookup_hist   = r_ghr;
  assign bus.lookup_ready  = w_lookupReady;
  assign bus.resolve_ready = !w_fifoFull;
  assign bus.update        = w_pop;
  assign bus.update_sel    = w_headEntry[INDEX:1];
  assign bus.up_down       = w_headEntry[0];

  // FSM state register; stall deliberately has no effect on it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Any accepted mispredict (re)enters RECOVER; RECOVER otherwise lasts one cycle.
  always_comb begin
    w_stateNext   = r_state;
    w_lookupReady = 1'b1;
    case (r_state)
      RUN: begin
        w_lookupReady = 1'b1;
        if (w_mispredict) begin
          w_stateNext = RECOVER;
        end
      end
      RECOVER: begin
        w_lookupReady = 1'b0;
        w_stateNext   = w_mispredict ? RECOVER : RUN;
      end
      default: begin
        w_stateNext   = RUN;
        w_lookupReady = 1'b1;
      end
    endcase
  end

  // History repair wins over speculation and ignores stall; speculation is frozen by stall.
  always_comb begin
    w_ghrNext = r_ghr;
    if (w_mispredict) begin
      w_ghrNext = {bus.resolve_hist[INDEX-2:0], bus.resolve_taken};
    end else if (w_lookupAccept && !stall) begin
      w_ghrNext = {r_ghr[INDEX-2:0], bus.pred};
    end
  end

  // Global history register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ghr <= '0;
    end else begin
      r_ghr <= w_ghrNext;
    end
  end

  pht_update_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INDEX + 1)
  ) u_updateFifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_resolveAccept),
    .i_pushData ({bus.resolve_idx, bus.resolve_taken}),
    .i_pop      (w_pop),
    .o_popData  (w_headEntry),
    .o_full     (w_fifoFull),
    .o_empty    (w_fifoEmpty)
  );

endmodule : pht_ctrl
